// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Time-multiplexes one external rectangle-overlap checker across the
//   collision targets of a frame. A frame_start_i request snapshots the ball
//   and paddle bounds, presents the ball (rect1) against one target per cycle
//   (rect2), collects the checker results CHK_LAT cycles later, and publishes
//   all results at once on hit_o together with a done_o pulse.
//
//   Optional feature: define COLLISION_WALLS_EN to add the top and bottom walls
//   as targets 2 and 3. Without it only the two paddles are checked and
//   hit_o[3:2] read 0.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   frame_start_i            single-cycle sweep request (ignored while busy_o)
//   ball_*_i, pl_*_i, pr_*_i ball / left paddle / right paddle bounds
//   rect1_*_o, rect2_*_o     checker operands (ball, current target); zero when not issuing
//   collision_i              checker result, CHK_LAT cycles after the operands
//   hit_o                    [0] left paddle [1] right paddle [2] top wall [3] bottom wall
//   busy_o                   sweep in progress
//   done_o                   one-cycle pulse as hit_o is updated
//   overrun_o                one-cycle pulse after a request dropped while busy
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 9
`endif

module collision_scheduler #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int WALL_T   = 4,
  parameter int CHK_LAT  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_start_i,
  input  logic [`X_POS_W-1:0] ball_left_i,
  input  logic [`X_POS_W-1:0] ball_right_i,
  input  logic [`Y_POS_W-1:0] ball_top_i,
  input  logic [`Y_POS_W-1:0] ball_bottom_i,
  input  logic [`X_POS_W-1:0] pl_left_i,
  input  logic [`X_POS_W-1:0] pl_right_i,
  input  logic [`Y_POS_W-1:0] pl_top_i,
  input  logic [`Y_POS_W-1:0] pl_bottom_i,
  input  logic [`X_POS_W-1:0] pr_left_i,
  input  logic [`X_POS_W-1:0] pr_right_i,
  input  logic [`Y_POS_W-1:0] pr_top_i,
  input  logic [`Y_POS_W-1:0] pr_bottom_i,
  output logic [`X_POS_W-1:0] rect1_left_o,
  output logic [`X_POS_W-1:0] rect1_right_o,
  output logic [`Y_POS_W-1:0] rect1_top_o,
  output logic [`Y_POS_W-1:0] rect1_bottom_o,
  output logic [`X_POS_W-1:0] rect2_left_o,
  output logic [`X_POS_W-1:0] rect2_right_o,
  output logic [`Y_POS_W-1:0] rect2_top_o,
  output logic [`Y_POS_W-1:0] rect2_bottom_o,
  input  logic                collision_i,
  output logic [3:0]          hit_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

`ifdef COLLISION_WALLS_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  localparam int IW = $clog2(N);
  localparam int XW = `X_POS_W;
  localparam int YW = `Y_POS_W;
  // Packed rectangle: {left, right, top, bottom}
  localparam int RW = 2*XW + 2*YW;

`ifdef COLLISION_WALLS_EN
  localparam logic [RW-1:0] WALL_TOP = {XW'(0), XW'(SCREEN_W), YW'(0), YW'(WALL_T)};
  localparam logic [RW-1:0] WALL_BOT = {XW'(0), XW'(SCREEN_W), YW'(SCREEN_H - WALL_T), YW'(SCREEN_H)};
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [2:0][RW-1:0]       snap_q, snap_d;     // [0] ball [1] left paddle [2] right paddle
  logic [N-1:0]             shadow_q, shadow_d;
  logic [N-1:0]             hit_q, hit_d;
  logic                     done_q, overrun_q;
  logic [CHK_LAT:1]         vld_pipe_q;
  logic [CHK_LAT:1][IW-1:0] tag_pipe_q;
  logic [RW-1:0]            r1, r2;
  logic                     accept, issue, smp, last;

  assign accept = (state_q == IDLE) && frame_start_i;
  assign issue  = (state_q == ISSUE);
  assign busy_o = (state_q != IDLE);

  // The tag leaving the last stage names the target whose result is on
  // collision_i right now; the final target's result closes the sweep.
  assign smp  = vld_pipe_q[CHK_LAT];
  assign last = smp && (tag_pipe_q[CHK_LAT] == IW'(N-1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (frame_start_i) begin
               state_d = ISSUE;
               idx_d   = '0;
             end
      ISSUE: if (idx_q == IW'(N-1)) begin
               state_d = DRAIN;
               idx_d   = '0;
             end else begin
               idx_d   = idx_q + IW'(1);
             end
      DRAIN: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- snapshot ----------------
  assign snap_d = accept ? {{pr_left_i, pr_right_i, pr_top_i, pr_bottom_i},
                            {pl_left_i, pl_right_i, pl_top_i, pl_bottom_i},
                            {ball_left_i, ball_right_i, ball_top_i, ball_bottom_i}}
                         : snap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) snap_q <= '0;
    else         snap_q <= snap_d;
  end

  // ---------------- checker operands ----------------
  // Zero operands outside ISSUE make the checker report no overlap, so stray
  // results in flight never look like hits.
  always_comb begin
    r1 = '0;
    r2 = '0;
    if (issue) begin
      r1 = snap_q[0];
      case (idx_q)
        IW'(0): r2 = snap_q[1];
        IW'(1): r2 = snap_q[2];
`ifdef COLLISION_WALLS_EN
        IW'(2): r2 = WALL_TOP;
        IW'(3): r2 = WALL_BOT;
`endif
        default: r2 = '0;
      endcase
    end
  end

  assign {rect1_left_o, rect1_right_o, rect1_top_o, rect1_bottom_o} = r1;
  assign {rect2_left_o, rect2_right_o, rect2_top_o, rect2_bottom_o} = r2;

  // ---------------- result tag pipeline ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= issue;
      tag_pipe_q[1] <= idx_q;
      for (int i = 2; i <= CHK_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  // ---------------- shadow / publish ----------------
  // hit_d takes shadow_d, not shadow_q, so the final target's result lands in
  // hit_o on the same edge it is sampled.
  always_comb begin
    shadow_d = shadow_q;
    hit_d    = hit_q;
    if (accept) shadow_d = '0;
    if (smp)    shadow_d[tag_pipe_q[CHK_LAT]] = collision_i;
    if (last)   hit_d = shadow_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= '0;
      hit_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      hit_q     <= hit_d;
      done_q    <= last;
      overrun_q <= frame_start_i && busy_o;
    end
  end

  assign done_o    = done_q;
  assign overrun_o = overrun_q;
`ifdef COLLISION_WALLS_EN
  assign hit_o = hit_q;
`else
  assign hit_o = {2'b00, hit_q};
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
module tb_collision_scheduler;
`ifdef COLLISION_WALLS_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif

  typedef struct packed {logic [9:0] l; logic [9:0] r; logic [8:0] t; logic [8:0] b;} rect_t;
  typedef struct packed {logic busy; logic done; logic ovr; logic [3:0] hit; rect_t r1; rect_t r2;} obs_t;

  localparam rect_t WALL_TOP = {10'd0, 10'd640, 9'd0,   9'd4};
  localparam rect_t WALL_BOT = {10'd0, 10'd640, 9'd476, 9'd480};

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  fs2 = 1'b0, fs3 = 1'b0;
  rect_t ball = '0, pl = '0, pr = '0;
  logic  col2, col3;
  obs_t  o2, o3;
  logic [3:0] cp2 = '0, cp3 = '0;
  logic [3:0] hexp2 = '0, hexp3 = '0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // Strict overlap: touching edges and zero-size rectangles do not collide.
  function automatic bit ovl(input rect_t a, input rect_t b);
    return (a.l < b.r) && (b.l < a.r) && (a.t < b.b) && (b.t < a.b);
  endfunction

  // Stand-in overlap checkers with latency 2 and 3.
  always @(posedge clk) begin
    cp2 <= {cp2[2:0], ovl(o2.r1, o2.r2)};
    cp3 <= {cp3[2:0], ovl(o3.r1, o3.r2)};
  end
  assign col2 = cp2[1];
  assign col3 = cp3[2];

  collision_scheduler #(.CHK_LAT(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs2),
    .ball_left_i(ball.l), .ball_right_i(ball.r), .ball_top_i(ball.t), .ball_bottom_i(ball.b),
    .pl_left_i(pl.l), .pl_right_i(pl.r), .pl_top_i(pl.t), .pl_bottom_i(pl.b),
    .pr_left_i(pr.l), .pr_right_i(pr.r), .pr_top_i(pr.t), .pr_bottom_i(pr.b),
    .rect1_left_o(o2.r1.l), .rect1_right_o(o2.r1.r), .rect1_top_o(o2.r1.t), .rect1_bottom_o(o2.r1.b),
    .rect2_left_o(o2.r2.l), .rect2_right_o(o2.r2.r), .rect2_top_o(o2.r2.t), .rect2_bottom_o(o2.r2.b),
    .collision_i(col2), .hit_o(o2.hit), .busy_o(o2.busy), .done_o(o2.done), .overrun_o(o2.ovr));

  collision_scheduler #(.CHK_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs3),
    .ball_left_i(ball.l), .ball_right_i(ball.r), .ball_top_i(ball.t), .ball_bottom_i(ball.b),
    .pl_left_i(pl.l), .pl_right_i(pl.r), .pl_top_i(pl.t), .pl_bottom_i(pl.b),
    .pr_left_i(pr.l), .pr_right_i(pr.r), .pr_top_i(pr.t), .pr_bottom_i(pr.b),
    .rect1_left_o(o3.r1.l), .rect1_right_o(o3.r1.r), .rect1_top_o(o3.r1.t), .rect1_bottom_o(o3.r1.b),
    .rect2_left_o(o3.r2.l), .rect2_right_o(o3.r2.r), .rect2_top_o(o3.r2.t), .rect2_bottom_o(o3.r2.b),
    .collision_i(col3), .hit_o(o3.hit), .busy_o(o3.busy), .done_o(o3.done), .overrun_o(o3.ovr));

  function automatic rect_t mk(input int l, input int t, input int w, input int h);
    rect_t x;
    x.l = 10'(l); x.r = 10'(l + w); x.t = 9'(t); x.b = 9'(t + h);
    return x;
  endfunction

  function automatic rect_t rnd_rect();
    return mk(int'($urandom_range(10, 600)), int'($urandom_range(0, 440)),
              int'($urandom_range(1, 39)), int'($urandom_range(1, 39)));
  endfunction

  // One sweep on the latency-`lat` instance. Cycle 0 is the request cycle;
  // with b2b set it is the current cycle (the previous sweep's done cycle).
  // extra != 0 re-asserts the request in that (busy) cycle.
  task automatic do_sweep(input int lat, input rect_t b, input rect_t l, input rect_t r,
                          input int extra, input bit b2b);
    int nl;
    rect_t tg[4];
    rect_t er1, er2;
    logic [3:0] exp_hit, ph, eh;
    obs_t o;
    nl = N + lat;
    tg[0] = l; tg[1] = r; tg[2] = WALL_TOP; tg[3] = WALL_BOT;
    exp_hit = '0;
    for (int k = 0; k < N; k++) exp_hit[k] = ovl(b, tg[k]);
    ph = (lat == 2) ? hexp2 : hexp3;
    if (!b2b) @(negedge clk);
    ball = b; pl = l; pr = r;
    if (lat == 2) fs2 = 1'b1; else fs3 = 1'b1;
    for (int c = 1; c <= nl + 1; c++) begin
      @(negedge clk);
      o   = (lat == 2) ? o2 : o3;
      er1 = (c <= N) ? b : '0;
      er2 = (c <= N) ? tg[c-1] : '0;
      eh  = (c == nl + 1) ? exp_hit : ph;
      n_chk++; if (o.busy !== (c <= nl))
        $display("FAIL busy lat%0d c%0d got %b exp %b", lat, c, o.busy, (c <= nl)); else n_pass++;
      n_chk++; if (o.done !== (c == nl + 1))
        $display("FAIL done lat%0d c%0d got %b exp %b", lat, c, o.done, (c == nl + 1)); else n_pass++;
      n_chk++; if (o.ovr !== (extra > 0 && c == extra + 1))
        $display("FAIL overrun lat%0d c%0d got %b exp %b", lat, c, o.ovr, (extra > 0 && c == extra + 1)); else n_pass++;
      n_chk++; if (o.hit !== eh)
        $display("FAIL hit lat%0d c%0d got %b exp %b", lat, c, o.hit, eh); else n_pass++;
      n_chk++; if (o.r1 !== er1)
        $display("FAIL rect1 lat%0d c%0d got %h exp %h", lat, c, o.r1, er1); else n_pass++;
      n_chk++; if (o.r2 !== er2)
        $display("FAIL rect2 lat%0d c%0d got %h exp %h", lat, c, o.r2, er2); else n_pass++;
      if (lat == 2) fs2 = (c == extra); else fs3 = (c == extra);
      // Scramble live inputs: the sweep must work from its snapshot.
      ball = rnd_rect(); pl = rnd_rect(); pr = rnd_rect();
    end
    if (lat == 2) hexp2 = exp_hit; else hexp3 = exp_hit;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (o2 !== '0) $display("FAIL reset_dut2 got %h exp 0", o2); else n_pass++;
    n_chk++; if (o3 !== '0) $display("FAIL reset_dut3 got %h exp 0", o3); else n_pass++;
    rst_n = 1'b1;
    hexp2 = '0; hexp3 = '0;
  endtask

  task automatic test_basic();
    do_sweep(2, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 0, 1'b0);
  endtask

  task automatic test_wall();
    do_sweep(2, mk(300, 2, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 0, 1'b0);
  endtask

  task automatic test_overrun();
    do_sweep(2, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_sweep(2, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 0, 1'b0);
    do_sweep(2, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(96, 180, 8, 60), 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ball = mk(100, 200, 10, 10); pl = mk(96, 180, 8, 60); pr = mk(600, 180, 8, 60);
    fs2 = 1'b1;
    @(negedge clk); fs2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (o2 !== '0) $display("FAIL midreset_dut2 got %h exp 0", o2); else n_pass++;
    n_chk++; if (o3 !== '0) $display("FAIL midreset_dut3 got %h exp 0", o3); else n_pass++;
    hexp2 = '0; hexp3 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if (o2.done !== 1'b0 || o2.busy !== 1'b0)
        $display("FAIL postreset_idle got done=%b busy=%b exp 0 0", o2.done, o2.busy); else n_pass++;
    end
    do_sweep(2, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 0, 1'b1);
  endtask

  task automatic test_lat3();
    do_sweep(3, mk(100, 200, 10, 10), mk(96, 180, 8, 60), mk(600, 180, 8, 60), 0, 1'b0);
  endtask

  task automatic test_random();
    rect_t b, l, r;
    int lat, extra;
    bit b2b;
    for (int it = 0; it < 30; it++) begin
      l = rnd_rect(); r = rnd_rect(); b = rnd_rect();
      case ($urandom_range(0, 4))
        0: b = mk(int'(l.l) + int'($urandom_range(0, 8)) - 4, int'(l.t) + int'($urandom_range(0, 60)) - 30,
                  int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
        1: b = mk(int'(r.l) + int'($urandom_range(0, 8)) - 4, int'(r.t) + int'($urandom_range(0, 60)) - 30,
                  int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
        2: b = mk(int'($urandom_range(10, 600)), int'($urandom_range(0, 6)), 10, 10);
        3: b = mk(int'($urandom_range(10, 600)), int'($urandom_range(462, 474)), 10, 10);
        default: ;
      endcase
      lat   = ($urandom_range(0, 1) == 1) ? 3 : 2;
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N + lat)) : 0;
      b2b   = (it > 0) && ($urandom_range(0, 1) == 1);
      do_sweep(lat, b, l, r, extra, b2b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter SCREEN_W, default 640: playfield width in pixels; right edge of the wall rectangles.
REQ-002 Parameter SCREEN_H, default 480: playfield height in pixels; bottom edge of the bottom wall.
REQ-003 Parameter WALL_T, default 4: wall thickness in pixels.
REQ-004 Parameter CHK_LAT, default 2, legal range 1-4: cycles from a rect pair on rect*_o to its result on collision_i.
REQ-005 clk_i  in  1  sole clock; all logic on the rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_start_i  in  1  single-cycle sweep request.
REQ-008 ball_{left,right}_i  in  `X_POS_W  ball x bounds; ball_{top,bottom}_i  in  `Y_POS_W  ball y bounds.
REQ-009 pl_{left,right,top,bottom}_i and pr_{left,right,top,bottom}_i  in  `X_POS_W/`Y_POS_W  left/right paddle bounds.
REQ-010 rect1_{left,right,top,bottom}_o  out  `X_POS_W/`Y_POS_W  shared checker operand 1 (always the ball).
REQ-011 rect2_{left,right,top,bottom}_o  out  `X_POS_W/`Y_POS_W  shared checker operand 2 (current target).
REQ-012 collision_i  in  1  result from the shared rectangle-overlap checker.
REQ-013 hit_o  out  4  per-target result: [0] left paddle, [1] right paddle, [2] top wall, [3] bottom wall.
REQ-014 busy_o  out  1  sweep in progress; done_o  out  1  one-cycle sweep-complete pulse; overrun_o  out  1  one-cycle dropped-request pulse.

Function
REQ-015 States: IDLE, ISSUE, DRAIN. N = 4 with the wall feature, else 2. Cycle 0 is the cycle frame_start_i is sampled high.
REQ-016 IDLE + frame_start_i: snapshot all ball and paddle inputs, idx <= 0, go to ISSUE; the snapshot holds constant for the whole sweep.
REQ-017 ISSUE: rect1*_o = ball snapshot, rect2*_o = target idx, driven combinationally; target k is presented in cycle 1+k; idx increments each cycle; after idx = N-1 go to DRAIN.
REQ-018 Wall rectangles: top = {0, SCREEN_W, 0, WALL_T}; bottom = {0, SCREEN_W, SCREEN_H-WALL_T, SCREEN_H}, given as {left, right, top, bottom}.
REQ-019 Outside ISSUE, all rect*_o are zero, so the checker returns no overlap.
REQ-020 collision_i is sampled in cycle 1+k+CHK_LAT into shadow bit k; a tag shift register of depth CHK_LAT tracks k.
REQ-021 DRAIN lasts until the last sample (cycle N+CHK_LAT), then the block goes to IDLE.
REQ-022 In cycle N+CHK_LAT+1, done_o = 1 and hit_o is loaded from the shadow atomically; hit_o otherwise holds between sweeps.
REQ-023 busy_o = 1 in cycles 1 through N+CHK_LAT, else 0.
REQ-024 frame_start_i is accepted only when busy_o = 0, including the done_o cycle; back-to-back sweeps are legal.
REQ-025 frame_start_i while busy_o = 1 is ignored: the sweep is unaffected and overrun_o pulses in the following cycle.

Reset
REQ-026 rst_ni low forces immediately: state IDLE, idx 0, tags clear, snapshot 0, hit_o 0, busy_o 0, done_o 0, overrun_o 0, rect*_o 0.
REQ-027 Reset mid-sweep aborts it with no done_o; the first frame_start_i after release starts a full sweep.

Configuration
REQ-028 With macro COLLISION_WALLS_EN defined: N = 4, walls checked as targets 2 and 3, done_o in cycle 5+CHK_LAT.
REQ-029 Without COLLISION_WALLS_EN: N = 2, no wall logic, hit_o[3:2] tied 0, done_o in cycle 3+CHK_LAT.

Verification
REQ-030 CHK_LAT=2, no macro: ball {100,110,200,210}, left paddle {96,104,180,240}, right paddle {600,608,180,240}, frame_start cycle 0 -> done_o cycle 5, hit_o=4'b0001, busy_o cycles 1-4.
REQ-031 Macro on, ball {300,310,2,12}, paddles as above -> rect2*_o = {0,640,0,4} in cycle 3; done_o cycle 7, hit_o=4'b0100.
REQ-032 Repeat of REQ-030 plus frame_start_i again in cycle 3 -> overrun_o cycle 4, done_o still cycle 5, hit_o=4'b0001.
REQ-033 REQ-030 setup, second frame_start in cycle 5 with right paddle moved to {96,104,180,240} -> second done_o cycle 10, hit_o=4'b0011.
REQ-034 rst_ni low in cycle 3 of a sweep -> all outputs 0 immediately, no done_o; frame_start 2 cycles after release -> done_o 5 cycles later.
REQ-035 CHK_LAT=3 with a bench checker model of matching latency, REQ-030 stimulus -> done_o cycle 6, hit_o=4'b0001.
